multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: USE_READY, default 1, meaning 1 = memory states wait on mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction opcode from instruction register, sampled in DECODE.
REQ-005 mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-006 pc_write, pc_write_cond  output  1 each  unconditional / branch-qualified PC update enables.
REQ-007 i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 mem_read, mem_write, ir_write  output  1 each  memory read/write strobes, instruction register load.
REQ-009 mem_to_reg, reg_dst, reg_write  output  1 each  register-file write data select, destination select, write enable.
REQ-010 alu_src_a  output  1; alu_src_b  output  2; alu_op  output  2; pc_source  output  2  datapath mux selects and ALU op class.
REQ-011 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 Decoded opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010; all others illegal.
REQ-014 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9; encodings 10-15 unreachable, return to FETCH next cycle with all strobes 0.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=1 and pc_write=1 only in the cycle mem_ready=1, then -> DECODE; else hold FETCH.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target); next by opcode: lw/sw -> MEMADR, R -> EXEC, beq -> BRANCH, j -> JUMP, illegal -> FETCH with illegal_op=1 for that cycle.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEMRD, sw -> MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1; -> MEMWB when mem_ready=1, else hold.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-020 MEMWR: mem_write=1, i_or_d=1; -> FETCH when mem_ready=1, else hold with mem_write held 1.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; -> FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-024 Outputs are Moore (function of state) except FETCH ir_write/pc_write, which are gated by mem_ready; unlisted outputs are 0 in each state.
REQ-025 opcode is latched in DECODE; opcode changes in later states of the same instruction have no effect.
REQ-026 Cycle counts with mem_ready=1: lw 5, sw 4, R 4, beq 3, j 3, illegal 2.
REQ-027 mem_ready changes during non-memory states have no effect.

Reset
REQ-028 reset=1 at a clock edge forces state=FETCH and clears latched opcode, overriding any transition, including mid-memory-wait.
REQ-029 While reset=1, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op) are 0; mux selects are 0.
REQ-030 First cycle after reset deasserts is FETCH with mem_read=1.

Structure
REQ-031 Opcode constants, state encodings and alu_op codes live in a shared package used by the control units and ALU control.
REQ-032 One sub-module natural: multicycle_control_decode, combinational state-to-output decode; next-state logic and opcode latch stay in the top.

Verification
REQ-033 lw with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-034 sw with mem_ready low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, state 5 held, then FETCH.
REQ-035 FETCH with mem_ready=0 for 2 cycles -> ir_write and pc_write stay 0 until mem_ready=1, single pulse then DECODE.
REQ-036 opcode 111111 -> states 0,1,0; illegal_op=1 exactly one cycle, reg_write/mem_write never 1.
REQ-037 reset asserted in MEMRD wait -> next state 0, all strobes 0 during reset, FETCH resumes after release.
REQ-038 beq then j -> pc_write_cond=1 with pc_source=01 in state 8, pc_write=1 with pc_source=10 in state 9.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control unit and ALU control:
// state encodings, opcode constants, ALU op classes and mux select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation classes handed to the ALU control unit
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-input select: register, constant 4, immediate, immediate << 2
  localparam logic [1:0] ALU_B_REG       = 2'b00;
  localparam logic [1:0] ALU_B_FOUR      = 2'b01;
  localparam logic [1:0] ALU_B_IMM       = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SHIFT = 2'b11;

  // PC source select: ALU result, ALU output register, jump target
  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control decode. Everything is Moore except the
// FETCH instruction-register / PC load, which waits for the memory, and
// the illegal-opcode flag, which is raised while DECODE sees a bad opcode.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic   reset,
  input  state_t state,
  input  logic   mem_done,
  input  logic   opcode_illegal,
  output ctrl_t  ctrl
);

  // Per-state control values; all outputs forced low while in reset
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = ALU_B_FOUR;
          ctrl.alu_op    = ALU_OP_ADD;
          ctrl.pc_source = PC_SRC_ALU;
          ctrl.ir_write  = mem_done;
          ctrl.pc_write  = mem_done;
        end
        S_DECODE: begin
          ctrl.alu_src_b  = ALU_B_IMM_SHIFT;
          ctrl.alu_op     = ALU_OP_ADD;
          ctrl.illegal_op = opcode_illegal;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALU_B_IMM;
          ctrl.alu_op    = ALU_OP_ADD;
        end
        S_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = ALU_B_REG;
          ctrl.alu_op    = ALU_OP_FUNCT;
        end
        S_RWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = ALU_B_REG;
          ctrl.alu_op        = ALU_OP_SUB;
          ctrl.pc_source     = PC_SRC_ALU_OUT;
          ctrl.pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PC_SRC_JUMP;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: state register, opcode latch and
// next-state logic; the per-state control decode lives in a sub-module.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int USE_READY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     cur_state;
  state_t     next_state;
  logic [5:0] op_latched;
  logic       mem_done;
  logic       opcode_illegal;
  ctrl_t      ctrl;

  // Builds without a memory handshake treat every access as single-cycle
  assign mem_done       = (USE_READY != 0) ? mem_ready : 1'b1;
  assign opcode_illegal = !is_legal_op(opcode);

  // State register and opcode latch; reset overrides any pending transition
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= S_FETCH;
      op_latched <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == S_DECODE) begin
        op_latched <= opcode;
      end
    end
  end

  // Next-state selection; memory states hold until the access completes
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_FETCH:  next_state = mem_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_latched == OP_LW) begin
          next_state = S_MEMRD;
        end else if (op_latched == OP_SW) begin
          next_state = S_MEMWR;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEMRD:  next_state = mem_done ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_done ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_RWB:    next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  multicycle_control_decode u_decode (
    .reset          (reset),
    .state          (cur_state),
    .mem_done       (mem_done),
    .opcode_illegal (opcode_illegal),
    .ctrl           (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level stimulus pushes
// the expected per-cycle control word; a monitor compares on the falling edge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  logic [20:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  multicycle_control #(.USE_READY(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for one cycle, taken from the per-state output table
  function automatic logic [20:0] exp_vec(input int st, input bit rdy, input bit ill, input bit rst);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill_o;
    logic [1:0] asb, aop, psrc;
    logic [3:0] st4;
    st4 = st[3:0];
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill_o} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    if (!rst) begin
      case (st)
        0: begin mr = 1'b1; asb = 2'b01; irw = rdy; pw = rdy; end
        1: begin asb = 2'b11; ill_o = ill; end
        2: begin asa = 1'b1; asb = 2'b10; end
        3: begin mr = 1'b1; iod = 1'b1; end
        4: begin rw = 1'b1; m2r = 1'b1; end
        5: begin mw = 1'b1; iod = 1'b1; end
        6: begin asa = 1'b1; aop = 2'b10; end
        7: begin rw = 1'b1; rd = 1'b1; end
        8: begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pwc = 1'b1; end
        9: begin pw = 1'b1; psrc = 2'b10; end
        default: ;
      endcase
    end
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill_o, st4};
  endfunction

  function automatic bit op_is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic apply_stimulus(input int st, input bit rdy, input logic [5:0] op, input bit rst, input bit ill);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    opcode    = op;
    exp_q.push_back(exp_vec(st, rdy, ill, rst));
  endtask

  task automatic check_output(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got=%b required=%b", name, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] rand_op();
    return 6'($urandom);
  endfunction

  // Run one instruction from FETCH; fetch_w/mem_w are memory wait cycles
  task automatic run_instr(input logic [5:0] op, input int fetch_w, input int mem_w);
    bit ill;
    ill = !op_is_legal(op);
    for (int i = 0; i < fetch_w; i++) apply_stimulus(0, 1'b0, rand_op(), 1'b0, 1'b0);
    apply_stimulus(0, 1'b1, rand_op(), 1'b0, 1'b0);
    apply_stimulus(1, 1'($urandom), op, 1'b0, ill);
    case (op)
      6'b100011: begin
        apply_stimulus(2, 1'($urandom), rand_op(), 1'b0, 1'b0);
        for (int i = 0; i < mem_w; i++) apply_stimulus(3, 1'b0, rand_op(), 1'b0, 1'b0);
        apply_stimulus(3, 1'b1, rand_op(), 1'b0, 1'b0);
        apply_stimulus(4, 1'($urandom), rand_op(), 1'b0, 1'b0);
      end
      6'b101011: begin
        apply_stimulus(2, 1'($urandom), rand_op(), 1'b0, 1'b0);
        for (int i = 0; i < mem_w; i++) apply_stimulus(5, 1'b0, rand_op(), 1'b0, 1'b0);
        apply_stimulus(5, 1'b1, rand_op(), 1'b0, 1'b0);
      end
      6'b000000: begin
        apply_stimulus(6, 1'($urandom), rand_op(), 1'b0, 1'b0);
        apply_stimulus(7, 1'($urandom), rand_op(), 1'b0, 1'b0);
      end
      6'b000100: apply_stimulus(8, 1'($urandom), rand_op(), 1'b0, 1'b0);
      6'b000010: apply_stimulus(9, 1'($urandom), rand_op(), 1'b0, 1'b0);
      default: ;
    endcase
  endtask

  // Monitor: compare each cycle's outputs against the oldest expectation
  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("cycle_ctrl",
                     {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal_op, state}, e);
      end
    end
  end

  // Directed scenarios followed by randomized instruction mix
  initial begin
    logic [5:0] ops[5];
    logic [5:0] op;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010;
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'b0;
    $display("[TB] start");

    apply_stimulus(0, 1'b1, 6'b0, 1'b1, 1'b0);
    apply_stimulus(0, 1'b0, 6'b100011, 1'b1, 1'b0);

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 2, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);

    // Reset while the load is waiting on memory in MEMRD
    apply_stimulus(0, 1'b1, rand_op(), 1'b0, 1'b0);
    apply_stimulus(1, 1'b0, 6'b100011, 1'b0, 1'b0);
    apply_stimulus(2, 1'b0, rand_op(), 1'b0, 1'b0);
    apply_stimulus(3, 1'b0, rand_op(), 1'b0, 1'b0);
    apply_stimulus(3, 1'b1, rand_op(), 1'b1, 1'b0);
    apply_stimulus(0, 1'b1, rand_op(), 1'b1, 1'b0);
    run_instr(6'b101011, 1, 1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = rand_op(); while (op_is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 4)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    check_output("queue_drained", 21'(exp_q.size()), 21'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
